// File: rtl/night_rider_scanner.sv
// night_rider_scanner: drives an LED bar with a scanning head and a PWM-faded trail.
// The divided step clock is treated as data: its rising level is edge-detected
// on the system clock, so the whole block lives in the clk_in domain.
module night_rider_scanner #(
    parameter int N_LED    = 8,
    parameter int TRAIL    = 3,
    parameter int PWM_BITS = 4,
    parameter int DWELL    = 0,
    localparam int PW      = $clog2(N_LED)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             step_in,
    input  logic             enable,
    input  logic             mode,
    output logic [N_LED-1:0] led,
    output logic [PW-1:0]    pos,
    output logic             dir
);

    // Keep history arrays at least one entry deep so TRAIL=0 still elaborates;
    // the unused slot is never lit.
    localparam int TR_N = (TRAIL > 0) ? TRAIL : 1;

    localparam logic [PW-1:0]       POS_MAX     = PW'(N_LED - 1);
    localparam logic [PW-1:0]       POS_TOP_RET = PW'(N_LED - 2);
    localparam logic [PW-1:0]       POS_ONE     = PW'(1);
    localparam logic [PW-1:0]       POS_ZERO    = '0;
    localparam logic [3:0]          DWELL_LAST  = 4'((DWELL > 0) ? (DWELL - 1) : 0);
    localparam logic [PWM_BITS-1:0] PWM_ONE     = PWM_BITS'(1);

    typedef enum logic [1:0] {
        SCAN_UP   = 2'd0,
        DWELL_TOP = 2'd1,
        SCAN_DN   = 2'd2,
        DWELL_BOT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_pos;
    logic [PW-1:0]       w_pos_next;
    logic [3:0]          r_dcnt;
    logic [3:0]          w_dcnt_next;
    logic                r_step_d;
    logic                w_step;
    logic                w_dir;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [N_LED-1:0]    r_led;
    logic [N_LED-1:0]    w_led_next;
    logic [PW-1:0]       r_hist_pos [TR_N];
    logic [TR_N-1:0]     r_hist_vld;
    logic [TR_N-1:0]     w_lit;

    // Edge detector: the delayed copy resets high so a step_in already high
    // when reset releases is not mistaken for a fresh step.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_step_d <= 1'b1;
        end else begin
            r_step_d <= step_in;
        end
    end

    assign w_step = step_in & ~r_step_d & enable;

    // FSM state register together with head position and dwell counter.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= SCAN_UP;
            r_pos   <= '0;
            r_dcnt  <= '0;
        end else if (w_step) begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
            r_dcnt  <= w_dcnt_next;
        end
    end

    // Next-state logic: wrap mode overrides the bounce FSM from any state.
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_dcnt_next  = r_dcnt;
        if (mode) begin
            w_state_next = SCAN_UP;
            w_dcnt_next  = '0;
            w_pos_next   = (r_pos == POS_MAX) ? POS_ZERO : (r_pos + POS_ONE);
        end else begin
            case (r_state)
                SCAN_UP: begin
                    if (r_pos != POS_MAX) begin
                        w_pos_next = r_pos + POS_ONE;
                    end else if (DWELL == 0) begin
                        w_state_next = SCAN_DN;
                        w_pos_next   = POS_TOP_RET;
                    end else begin
                        w_state_next = DWELL_TOP;
                        w_dcnt_next  = '0;
                    end
                end
                DWELL_TOP: begin
                    w_dcnt_next = r_dcnt + 4'd1;
                    if (r_dcnt == DWELL_LAST) begin
                        w_state_next = SCAN_DN;
                        w_pos_next   = POS_TOP_RET;
                    end
                end
                SCAN_DN: begin
                    if (r_pos != POS_ZERO) begin
                        w_pos_next = r_pos - POS_ONE;
                    end else if (DWELL == 0) begin
                        w_state_next = SCAN_UP;
                        w_pos_next   = POS_ONE;
                    end else begin
                        w_state_next = DWELL_BOT;
                        w_dcnt_next  = '0;
                    end
                end
                default: begin
                    w_dcnt_next = r_dcnt + 4'd1;
                    if (r_dcnt == DWELL_LAST) begin
                        w_state_next = SCAN_UP;
                        w_pos_next   = POS_ONE;
                    end
                end
            endcase
        end
    end

    // Output decode: direction is "down" while heading down or parked at the top.
    always_comb begin
        w_dir = (r_state == SCAN_DN) || (r_state == DWELL_TOP);
    end

    // Trail history: newest previous head position in slot 0, older ones shift out.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int k = 0; k < TR_N; k++) begin
                r_hist_pos[k] <= '0;
            end
            r_hist_vld <= '0;
        end else if (w_step) begin
            r_hist_pos[0] <= r_pos;
            r_hist_vld[0] <= (TRAIL > 0);
            for (int k = 1; k < TR_N; k++) begin
                r_hist_pos[k] <= r_hist_pos[k-1];
                r_hist_vld[k] <= r_hist_vld[k-1];
            end
        end
    end

    // Free-running PWM counter, independent of enable.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
        end
    end

    // Each trail slot k (1-based) is lit for 2^PWM_BITS >> k counts per period.
    // Dimmer slots are strict subsets of brighter ones, so OR-ing sources per LED
    // gives the brightest-wins result without an explicit priority mux.
    genvar gi, gk;
    generate
        for (gi = 0; gi < TR_N; gi++) begin : g_lit
            localparam int              THR   = (1 << PWM_BITS) >> (gi + 1);
            localparam logic [PWM_BITS:0] THR_V = (PWM_BITS + 1)'(THR);
            assign w_lit[gi] = (gi < TRAIL) && r_hist_vld[gi] &&
                               ({1'b0, r_pwm_cnt} < THR_V);
        end

        for (gi = 0; gi < N_LED; gi++) begin : g_led
            logic [TR_N-1:0] w_hit;
            for (gk = 0; gk < TR_N; gk++) begin : g_slot
                assign w_hit[gk] = w_lit[gk] && (r_hist_pos[gk] == PW'(gi));
            end
            assign w_led_next[gi] = (r_pos == PW'(gi)) || (|w_hit);
        end
    endgenerate

    // Registered LED drive.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign led = r_led;
    assign pos = r_pos;
    assign dir = w_dir;

endmodule
